// File: rtl/tcp_client_control.sv
// Active-open TCP connection controller: drives the client state machine and
// hands control-segment requests (SYN/ACK/FIN/RST) to the TX framer.
module tcp_client_control #(
  parameter int RTO_CYCLES       = 1000,
  parameter int MAX_RETRIES      = 3,
  parameter int TIME_WAIT_CYCLES = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        connect_in,
  input  logic        force_dcn_in,
  input  logic        tx_done_in,
  input  logic        rx_vld,
  input  logic        SYN_in,
  input  logic        ACK_in,
  input  logic        FIN_in,
  input  logic        RST_in,
  input  logic [15:0] src_port_in,
  input  logic [15:0] dst_port_in,
  input  logic [15:0] local_port,
  input  logic [15:0] remote_port,
  input  logic        tx_rdy,
  output logic        tx_vld,
  output logic        tx_syn,
  output logic        tx_ack,
  output logic        tx_fin,
  output logic        tx_rst,
  output logic [2:0]  state_out,
  output logic        connected,
  output logic        timeout_err,
  output logic        reset_err
);

  localparam int RTO_W = (RTO_CYCLES > 1) ? $clog2(RTO_CYCLES) : 1;
  localparam int TW_W  = (TIME_WAIT_CYCLES > 1) ? $clog2(TIME_WAIT_CYCLES) : 1;
  localparam int RET_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  // Flag vectors are ordered {syn, ack, fin, rst}
  localparam logic [3:0] F_SYN = 4'b1000;
  localparam logic [3:0] F_ACK = 4'b0100;
  localparam logic [3:0] F_FIN = 4'b0010;
  localparam logic [3:0] F_RST = 4'b0001;

  typedef enum logic [2:0] {
    CLOSED      = 3'd0,
    SYN_SENT    = 3'd1,
    ESTABLISHED = 3'd2,
    FIN_WAIT_1  = 3'd3,
    FIN_WAIT_2  = 3'd4,
    TIME_WAIT   = 3'd5,
    LAST_ACK    = 3'd6
  } state_t;

  state_t           state_reg, state_next;
  logic [RTO_W-1:0] rto_reg, rto_next;
  logic [TW_W-1:0]  tw_reg, tw_next;
  logic [RET_W-1:0] retry_reg, retry_next;
  logic             tx_vld_reg, tx_vld_next;
  logic [3:0]       tx_flags_reg, tx_flags_next;
  logic             connected_reg, timeout_err_reg, timeout_err_next;
  logic             reset_err_reg, reset_err_next;
  logic             issue;
  logic [3:0]       issue_flags;
  logic             match, rto_expired, timed_state;

  assign match       = rx_vld && (src_port_in == remote_port) && (dst_port_in == local_port);
  assign rto_expired = (rto_reg == RTO_W'(RTO_CYCLES - 1)) && !tx_vld_reg;
  assign timed_state = (state_reg == SYN_SENT) || (state_reg == FIN_WAIT_1) ||
                       (state_reg == LAST_ACK);

  always_comb begin
    state_next       = state_reg;
    rto_next         = rto_reg;
    tw_next          = tw_reg;
    retry_next       = retry_reg;
    issue            = 1'b0;
    issue_flags      = 4'b0000;
    timeout_err_next = 1'b0;
    reset_err_next   = 1'b0;

    if (state_reg == CLOSED) begin
      if (connect_in) begin
        issue       = 1'b1;
        issue_flags = F_SYN;
        retry_next  = '0;
        state_next  = SYN_SENT;
      end
    end else if (force_dcn_in) begin
      issue       = 1'b1;
      issue_flags = F_RST;
      state_next  = CLOSED;
    end else if (match && RST_in) begin
      reset_err_next = 1'b1;
      state_next     = CLOSED;
    end else begin
      case (state_reg)
        SYN_SENT: begin
          if (match && SYN_in && ACK_in) begin
            issue       = 1'b1;
            issue_flags = F_ACK;
            state_next  = ESTABLISHED;
          end
        end
        ESTABLISHED: begin
          if (match && FIN_in) begin
            issue       = 1'b1;
            issue_flags = F_FIN | F_ACK;
            retry_next  = '0;
            state_next  = LAST_ACK;
          end else if (!connect_in && tx_done_in) begin
            issue       = 1'b1;
            issue_flags = F_FIN | F_ACK;
            retry_next  = '0;
            state_next  = FIN_WAIT_1;
          end
        end
        FIN_WAIT_1: begin
          if (match && FIN_in) begin
            issue       = 1'b1;
            issue_flags = F_ACK;
            state_next  = TIME_WAIT;
          end else if (match && ACK_in) begin
            state_next = FIN_WAIT_2;
          end
        end
        FIN_WAIT_2: begin
          if (match && FIN_in) begin
            issue       = 1'b1;
            issue_flags = F_ACK;
            state_next  = TIME_WAIT;
          end
        end
        TIME_WAIT: begin
          if (match && FIN_in) begin
            issue       = 1'b1;
            issue_flags = F_ACK;
            tw_next     = '0;
          end else if (tw_reg == TW_W'(TIME_WAIT_CYCLES - 1)) begin
            state_next = CLOSED;
          end else begin
            tw_next = tw_reg + 1'b1;
          end
        end
        LAST_ACK: begin
          if (match && ACK_in) state_next = CLOSED;
        end
        default: state_next = CLOSED;
      endcase

      // A matching segment in the expiry cycle suppresses the timeout action
      if (timed_state && state_next == state_reg) begin
        if (rto_expired && !match) begin
          issue    = 1'b1;
          rto_next = '0;
          if (retry_reg < RET_W'(MAX_RETRIES)) begin
            issue_flags = (state_reg == SYN_SENT) ? F_SYN : (F_FIN | F_ACK);
            retry_next  = retry_reg + 1'b1;
          end else begin
            issue_flags      = F_RST;
            timeout_err_next = 1'b1;
            state_next       = CLOSED;
          end
        end else if (!tx_vld_reg && !rto_expired) begin
          rto_next = rto_reg + 1'b1;
        end
      end
    end

    if (state_next != state_reg) begin
      rto_next = '0;
      tw_next  = '0;
    end

    tx_vld_next   = tx_vld_reg;
    tx_flags_next = tx_flags_reg;
    if (issue) begin
      tx_vld_next   = 1'b1;
      tx_flags_next = issue_flags;
    end else if (tx_vld_reg && tx_rdy) begin
      tx_vld_next   = 1'b0;
      tx_flags_next = 4'b0000;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= CLOSED;
      rto_reg         <= '0;
      tw_reg          <= '0;
      retry_reg       <= '0;
      tx_vld_reg      <= 1'b0;
      tx_flags_reg    <= 4'b0000;
      connected_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
      reset_err_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rto_reg         <= rto_next;
      tw_reg          <= tw_next;
      retry_reg       <= retry_next;
      tx_vld_reg      <= tx_vld_next;
      tx_flags_reg    <= tx_flags_next;
      connected_reg   <= (state_next == ESTABLISHED);
      timeout_err_reg <= timeout_err_next;
      reset_err_reg   <= reset_err_next;
    end
  end

  assign tx_vld      = tx_vld_reg;
  assign tx_syn      = tx_flags_reg[3];
  assign tx_ack      = tx_flags_reg[2];
  assign tx_fin      = tx_flags_reg[1];
  assign tx_rst      = tx_flags_reg[0];
  assign state_out   = state_reg;
  assign connected   = connected_reg;
  assign timeout_err = timeout_err_reg;
  assign reset_err   = reset_err_reg;

endmodule

// File: tb/tb_tcp_client_control.sv
// Directed bench for tcp_client_control: a monitor scores every TX handshake
// against a queue of expected flag sets; stimulus checks state and pulses.
module tb_tcp_client_control;

  localparam int RTO  = 8;
  localparam int MAXR = 2;
  localparam int TW   = 16;

  localparam logic [3:0] F_SYN = 4'b1000;
  localparam logic [3:0] F_ACK = 4'b0100;
  localparam logic [3:0] F_FIN = 4'b0010;
  localparam logic [3:0] F_RST = 4'b0001;

  localparam logic [15:0] LPORT = 16'd1000;
  localparam logic [15:0] RPORT = 16'd80;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        connect_in = 1'b0, force_dcn_in = 1'b0, tx_done_in = 1'b1;
  logic        rx_vld = 1'b0, SYN_in = 1'b0, ACK_in = 1'b0, FIN_in = 1'b0, RST_in = 1'b0;
  logic [15:0] src_port_in = RPORT, dst_port_in = LPORT;
  logic [15:0] local_port = LPORT, remote_port = RPORT;
  logic        tx_rdy = 1'b0;
  logic        tx_vld, tx_syn, tx_ack, tx_fin, tx_rst;
  logic [2:0]  state_out;
  logic        connected, timeout_err, reset_err;

  tcp_client_control #(
    .RTO_CYCLES(RTO), .MAX_RETRIES(MAXR), .TIME_WAIT_CYCLES(TW)
  ) dut (
    .clk(clk), .rst(rst), .connect_in(connect_in), .force_dcn_in(force_dcn_in),
    .tx_done_in(tx_done_in), .rx_vld(rx_vld), .SYN_in(SYN_in), .ACK_in(ACK_in),
    .FIN_in(FIN_in), .RST_in(RST_in), .src_port_in(src_port_in),
    .dst_port_in(dst_port_in), .local_port(local_port), .remote_port(remote_port),
    .tx_rdy(tx_rdy), .tx_vld(tx_vld), .tx_syn(tx_syn), .tx_ack(tx_ack),
    .tx_fin(tx_fin), .tx_rst(tx_rst), .state_out(state_out), .connected(connected),
    .timeout_err(timeout_err), .reset_err(reset_err)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] exp_q[$];
  int         gap_q[$];
  int         idle = 0;

  // Scoreboard monitor: one line per accepted control segment
  always @(negedge clk) begin
    logic [3:0] got, req;
    if (tx_vld && tx_rdy) begin
      got = {tx_syn, tx_ack, tx_fin, tx_rst};
      gap_q.push_back(idle);
      idle = 0;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL tx_segment got=%b required=none (unexpected)", got);
      end else begin
        req = exp_q.pop_front();
        if (got !== req) begin
          miscompares++;
          $display("FAIL tx_segment got=%b required=%b", got, req);
        end else begin
          $display("tx_segment flags=%b idle_before=%0d", got, gap_q[gap_q.size()-1]);
        end
      end
    end else if (!tx_vld) begin
      idle++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end else begin
      $display("check %s = %0h", name, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic seg(input logic [3:0] f, input logic [15:0] src, input logic [15:0] dst);
    rx_vld = 1'b1;
    {SYN_in, ACK_in, FIN_in, RST_in} = f;
    src_port_in = src;
    dst_port_in = dst;
    step();
    rx_vld = 1'b0;
    {SYN_in, ACK_in, FIN_in, RST_in} = 4'b0000;
    src_port_in = RPORT;
    dst_port_in = LPORT;
  endtask

  task automatic open_conn();
    connect_in = 1'b1;
    exp_q.push_back(F_SYN);
    step();
    exp_q.push_back(F_ACK);
    seg(F_SYN | F_ACK, RPORT, LPORT);
  endtask

  initial begin
    int base;
    bit seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(state_out), 32'd0);
    check("reset_outputs", 32'({tx_vld, tx_syn, tx_ack, tx_fin, tx_rst, connected, timeout_err, reset_err}), 32'd0);
    rst = 1'b1;
    tx_rdy = 1'b1;
    step();

    // Open
    connect_in = 1'b1;
    exp_q.push_back(F_SYN);
    step();
    check("open_syn_state", 32'(state_out), 32'd1);
    check("open_syn_flags", 32'({tx_vld, tx_syn, tx_ack, tx_fin, tx_rst}), 32'b11000);
    step();
    exp_q.push_back(F_ACK);
    seg(F_SYN | F_ACK, RPORT, LPORT);
    check("open_est_state", 32'(state_out), 32'd2);
    check("open_connected", 32'(connected), 32'd1);
    check("open_ack_flags", 32'({tx_vld, tx_syn, tx_ack, tx_fin, tx_rst}), 32'b10100);

    // Non-matching FIN segments are ignored
    seg(F_FIN, RPORT + 16'd1, LPORT);
    check("nomatch_src_state", 32'(state_out), 32'd2);
    seg(F_FIN, RPORT, LPORT + 16'd1);
    check("nomatch_dst_state", 32'({state_out, tx_vld}), 32'({3'd2, 1'b0}));

    // Passive close
    connect_in = 1'b0;
    tx_done_in = 1'b0;
    step();
    check("est_hold_busy", 32'(state_out), 32'd2);
    exp_q.push_back(F_FIN | F_ACK);
    seg(F_FIN, RPORT, LPORT);
    check("passive_last_ack", 32'(state_out), 32'd6);
    seg(F_ACK, RPORT + 16'd1, LPORT);
    check("passive_nomatch_ack", 32'(state_out), 32'd6);
    seg(F_ACK, RPORT, LPORT);
    check("passive_closed", 32'({state_out, connected}), 32'd0);

    // Active close
    open_conn();
    check("active_est", 32'(state_out), 32'd2);
    connect_in = 1'b0;
    tx_done_in = 1'b1;
    exp_q.push_back(F_FIN | F_ACK);
    step();
    check("active_fw1", 32'(state_out), 32'd3);
    seg(F_ACK, RPORT, LPORT);
    check("active_fw2", 32'(state_out), 32'd4);
    repeat (3 * RTO) step();
    check("fw2_no_timer", 32'({state_out, tx_vld}), 32'({3'd4, 1'b0}));
    exp_q.push_back(F_ACK);
    seg(F_FIN, RPORT, LPORT);
    check("active_time_wait", 32'(state_out), 32'd5);
    repeat (TW - 1) step();
    check("time_wait_last_cycle", 32'(state_out), 32'd5);
    step();
    check("time_wait_done", 32'(state_out), 32'd0);

    // Abort precedence: force_dcn over matching RST
    tx_done_in = 1'b0;
    open_conn();
    connect_in = 1'b0;
    force_dcn_in = 1'b1;
    exp_q.push_back(F_RST);
    seg(F_RST, RPORT, LPORT);
    force_dcn_in = 1'b0;
    check("abort_state", 32'(state_out), 32'd0);
    check("abort_reset_err", 32'(reset_err), 32'd0);
    check("abort_tx_rst", 32'({tx_vld, tx_rst}), 32'b11);
    step();

    // Matching RST alone
    open_conn();
    step();
    connect_in = 1'b0;
    seg(F_RST, RPORT, LPORT);
    check("rst_in_state", 32'(state_out), 32'd0);
    check("rst_in_pulse", 32'({reset_err, tx_vld}), 32'b10);
    step();
    check("rst_in_pulse_end", 32'(reset_err), 32'd0);

    // Retry exhaustion
    base = gap_q.size();
    connect_in = 1'b1;
    exp_q.push_back(F_SYN);
    exp_q.push_back(F_SYN);
    exp_q.push_back(F_SYN);
    exp_q.push_back(F_RST);
    step();
    connect_in = 1'b0;
    check("retry_syn_sent", 32'(state_out), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      if (timeout_err) seen = 1'b1;
    end
    check("retry_timeout_seen", 32'(seen), 32'd1);
    check("retry_abort_state", 32'({state_out, tx_vld, tx_rst}), 32'({3'd0, 2'b11}));
    step();
    check("retry_pulse_end", 32'(timeout_err), 32'd0);
    check("retry_gap_count", 32'(gap_q.size() - base), 32'd4);
    for (int i = 1; i < 4; i++) begin
      if (base + i < gap_q.size()) check($sformatf("retry_gap_%0d", i), 32'(gap_q[base + i]), 32'(RTO));
    end

    // Backpressure: timer held while a request is pending, latest flags win
    tx_rdy = 1'b0;
    connect_in = 1'b1;
    step();
    connect_in = 1'b0;
    check("bp_syn_pending", 32'({state_out, tx_vld, tx_syn, tx_ack, tx_fin, tx_rst}), 32'({3'd1, 5'b11000}));
    repeat (3 * RTO + 4) step();
    check("bp_timer_held", 32'({state_out, tx_vld, tx_syn, tx_ack, tx_fin, tx_rst}), 32'({3'd1, 5'b11000}));
    seg(F_SYN | F_ACK, RPORT, LPORT);
    check("bp_overwrite_ack", 32'({state_out, tx_vld, tx_syn, tx_ack, tx_fin, tx_rst}), 32'({3'd2, 5'b10100}));
    step();

    // Asynchronous reset mid-connection
    #3 rst = 1'b0;
    #1;
    check("async_rst_outputs", 32'({state_out, tx_vld, tx_syn, tx_ack, tx_fin, tx_rst, connected, timeout_err, reset_err}), 32'd0);
    step();
    rst = 1'b1;
    tx_rdy = 1'b1;
    repeat (3) step();
    check("after_rst_idle", 32'({state_out, tx_vld}), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/tcp_client_control.md
# tcp_client_control

Active-open TCP connection controller: the client-side counterpart of the TCP server control FSM. It sequences CLOSED → SYN_SENT → ESTABLISHED, then through active close (FIN_WAIT_1/2, TIME_WAIT) or passive close (LAST_ACK). It consumes pre-parsed inbound segment flags and issues control-segment requests, with retransmission and timeout, to the TX framer through a one-entry valid/ready register.

## Interface
- RTO_CYCLES, 1000: retransmission timeout, in clk cycles.
- MAX_RETRIES, 3: retransmissions allowed before abort.
- TIME_WAIT_CYCLES, 2000: TIME_WAIT dwell, in clk cycles.

- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- connect_in  in  1  level: 1 = open/hold the connection, 0 = request close.
- force_dcn_in  in  1  abort request; sends RST.
- tx_done_in  in  1  payload path idle; a graceful close is allowed only when this is 1.
- rx_vld  in  1  inbound segment strobe, one cycle per segment.
- SYN_in, ACK_in, FIN_in, RST_in  in  1 each  inbound flags, qualified by rx_vld.
- src_port_in, dst_port_in  in  16 each  inbound ports.
- local_port, remote_port  in  16 each  connection ports, static while not CLOSED.
- tx_rdy  in  1  framer accepts the pending request.
- tx_vld  out  1  control-segment request pending.
- tx_syn, tx_ack, tx_fin, tx_rst  out  1 each  flags of the pending request.
- state_out  out  3  CLOSED=0, SYN_SENT=1, ESTABLISHED=2, FIN_WAIT_1=3, FIN_WAIT_2=4, TIME_WAIT=5, LAST_ACK=6.
- connected  out  1  1 iff state is ESTABLISHED.
- timeout_err  out  1  one-cycle pulse on retry exhaustion.
- reset_err  out  1  one-cycle pulse on a matching inbound RST.

## Operation
- Matching segment: rx_vld && src_port_in==remote_port && dst_port_in==local_port. Non-matching segments are ignored entirely.
- Issue(F): loads the TX register with flags F and sets tx_vld. A new Issue while tx_vld=1 overwrites the flags (latest wins). tx_vld clears on the cycle after tx_vld&&tx_rdy unless a new Issue occurs in that same cycle.
- Event priority, every state except CLOSED:
  1. force_dcn_in → Issue(RST) → CLOSED.
  2. Matching RST_in → CLOSED, pulse reset_err, no Issue.
  3. Matching segment rules below.
  4. Timeout.
- CLOSED: connect_in=1 → Issue(SYN), clear retry_cnt, → SYN_SENT.
- SYN_SENT:
  - matching SYN&ACK → Issue(ACK) → ESTABLISHED.
  - other matching segments are ignored.
- ESTABLISHED:
  - matching FIN → Issue(FIN|ACK), clear retry_cnt, → LAST_ACK.
  - else connect_in=0 && tx_done_in → Issue(FIN|ACK), clear retry_cnt, → FIN_WAIT_1.
  - connect_in=0 with tx_done_in=0: stay.
- FIN_WAIT_1:
  - matching FIN (ACK set or not) → Issue(ACK) → TIME_WAIT.
  - matching ACK without FIN → FIN_WAIT_2.
- FIN_WAIT_2: matching FIN → Issue(ACK) → TIME_WAIT. No timer runs here.
- TIME_WAIT:
  - counter reaches TIME_WAIT_CYCLES-1 → CLOSED.
  - matching FIN → Issue(ACK) and restart the counter.
- LAST_ACK: matching ACK → CLOSED.
- Retransmit timer (SYN_SENT, FIN_WAIT_1, LAST_ACK):
  - zeroed on state entry and on each retransmit.
  - increments only while tx_vld=0.
  - expiry = count==RTO_CYCLES-1 && tx_vld=0.
  - on expiry with retry_cnt<MAX_RETRIES: re-Issue the state's segment (SYN, FIN|ACK, FIN|ACK respectively) and increment retry_cnt.
  - on expiry with retry_cnt==MAX_RETRIES: Issue(RST), pulse timeout_err, → CLOSED.
- Counter widths: $clog2 of the parameter, minimum 1 bit. No wrap, because counters clear on expiry.

## Timing
- Reset (rst=0, asynchronous): state CLOSED, all outputs 0, counters and retry_cnt 0.
- All outputs are registered.
- Input event at edge N → state_out, tx_* and pulses change at edge N+1.
- tx flags are stable while tx_vld=1 && tx_rdy=0, except when a higher-priority Issue overwrites them.
- A tx_vld request is completed by reset or by tx_rdy only; force_dcn_in overwrites it with RST.
- rx_vld in the same cycle as an expiry: the segment wins and the timer does not fire.
- rst deasserting mid-connection: restart from CLOSED with no RST sent.

## Test plan
- Open: connect_in=1, then matching SYN&ACK → tx SYN, state 1; then tx ACK, state 2, connected=1 one cycle after the segment.
- Retry exhaustion: RTO_CYCLES=8, MAX_RETRIES=2, tx_rdy=1, no reply → 2 SYN retransmits spaced 8 cycles apart, then RST, timeout_err pulse, state 0.
- Active close: ESTABLISHED with connect_in=0 and tx_done_in=1 → FIN|ACK, state 3. Inbound ACK → state 4. Inbound FIN → ACK, state 5. After TIME_WAIT_CYCLES → state 0.
- Passive close: inbound FIN in ESTABLISHED → FIN|ACK, state 6. Inbound ACK → state 0. Repeat with src_port_in≠remote_port → no reaction.
- Abort precedence: force_dcn_in and matching RST_in in the same cycle in ESTABLISHED → tx_rst=1, reset_err=0, state 0. Matching RST alone → reset_err pulse, tx_vld stays 0.
- Backpressure: tx_rdy=0 while a SYN is pending and SYN&ACK arrives → flags switch to ACK only. Timer held at 0 while tx_vld=1. rst asserted mid-stream → all outputs 0 immediately.
